// File: rtl/aes_axil_driver_if.sv
//------------------------------------------------------------------------------
// Module   : aes_axil_driver_if
// Purpose  : AXI4-Lite bus bundle between the AES job driver (master) and the
//            memory-mapped AES slave.
// Ports    : write address (m_aw_*), write data (m_w_*), write response
//            (m_b_*), read address (m_ar_*), read data/response (m_r_*).
// Modports : master - driver side, slave - AES peripheral side.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

interface aes_axil_driver_if;
  logic [31:0] m_aw_addr;
  logic        m_aw_valid;
  logic        m_aw_ready;
  logic [31:0] m_w_data;
  logic [3:0]  m_w_strb;
  logic        m_w_valid;
  logic        m_w_ready;
  logic [1:0]  m_b_resp;
  logic        m_b_valid;
  logic        m_b_ready;
  logic [31:0] m_ar_addr;
  logic        m_ar_valid;
  logic        m_ar_ready;
  logic [31:0] m_r_data;
  logic [1:0]  m_r_resp;
  logic        m_r_valid;
  logic        m_r_ready;

  modport master (
    output m_aw_addr, m_aw_valid, input m_aw_ready,
    output m_w_data, m_w_strb, m_w_valid, input m_w_ready,
    input  m_b_resp, m_b_valid, output m_b_ready,
    output m_ar_addr, m_ar_valid, input m_ar_ready,
    input  m_r_data, m_r_resp, m_r_valid, output m_r_ready
  );

  modport slave (
    input  m_aw_addr, m_aw_valid, output m_aw_ready,
    input  m_w_data, m_w_strb, m_w_valid, output m_w_ready,
    output m_b_resp, m_b_valid, input m_b_ready,
    input  m_ar_addr, m_ar_valid, output m_ar_ready,
    output m_r_data, m_r_resp, m_r_valid, input m_r_ready
  );
endinterface

`default_nettype wire

// File: rtl/aes_axil_driver.sv
//------------------------------------------------------------------------------
// Module   : aes_axil_driver
// Purpose  : Runs one AES job over AXI4-Lite: writes the 192-bit key, the
//            128-bit plaintext and START, polls DONE, reads back the 128-bit
//            ciphertext and hands it out on a valid/ready port.
// Ports    : clk_i, rst_ni (async, active-low)
//            in_valid/in_ready/in_key/in_pt   - job request
//            out_valid/out_ready/out_ct       - job result
//            m (aes_axil_driver_if.master)    - AXI4-Lite master bus
//            busy_o - not idle, err_o - sticky bus/timeout error
// Options  : AES_DRV_POLL_TIMEOUT_EN - when defined, give up after POLL_LIMIT
//            DONE reads that return bit0=0.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module aes_axil_driver #(
  parameter logic [31:0] BASE_ADDR  = 32'h0,
  parameter int          POLL_LIMIT = 1024
) (
  input  wire logic          clk_i,
  input  wire logic          rst_ni,
  input  wire logic          in_valid,
  output logic               in_ready,
  input  wire logic [191:0]  in_key,
  input  wire logic [127:0]  in_pt,
  output logic               out_valid,
  input  wire logic          out_ready,
  output logic [127:0]       out_ct,
  aes_axil_driver_if.master  m,
  output logic               busy_o,
  output logic               err_o
);

  localparam logic [2:0] c_st_idle     = 3'd0;
  localparam logic [2:0] c_st_wr_key   = 3'd1;
  localparam logic [2:0] c_st_wr_pt    = 3'd2;
  localparam logic [2:0] c_st_wr_start = 3'd3;
  localparam logic [2:0] c_st_poll     = 3'd4;
  localparam logic [2:0] c_st_rd_ct    = 3'd5;
  localparam logic [2:0] c_st_out      = 3'd6;

  localparam logic [31:0] c_off_key   = 32'h10;
  localparam logic [31:0] c_off_pt    = 32'h00;
  localparam logic [31:0] c_off_start = 32'h28;
  localparam logic [31:0] c_off_done  = 32'h2C;
  localparam logic [31:0] c_off_ct    = 32'h30;

  if (POLL_LIMIT < 1) begin : g_poll_limit_check
    $error("aes_axil_driver: POLL_LIMIT must be at least 1");
  end

  logic [2:0]   r_state;
  logic [2:0]   w_next;
  logic         r_aw_done;
  logic         r_w_done;
  logic         r_ar_done;
  logic [2:0]   r_word_cnt;
  logic [191:0] r_key;
  logic [127:0] r_pt;
  logic [127:0] r_ct;
  logic         r_err;

  logic w_accept;
  logic w_wr_state;
  logic w_rd_state;
  logic w_b_fire;
  logic w_r_fire;
  logic w_b_err;
  logic w_r_err;
  logic w_last_word;
  logic w_poll_timeout;

  assign w_accept   = in_valid & in_ready;
  assign w_wr_state = (r_state == c_st_wr_key) | (r_state == c_st_wr_pt) |
                      (r_state == c_st_wr_start);
  assign w_rd_state = (r_state == c_st_poll) | (r_state == c_st_rd_ct);
  assign w_b_fire   = m.m_b_valid & m.m_b_ready;
  assign w_r_fire   = m.m_r_valid & m.m_r_ready;
  assign w_b_err    = w_b_fire & (m.m_b_resp != 2'b00);
  assign w_r_err    = w_r_fire & (m.m_r_resp != 2'b00);

  // Last beat of the current multi-word phase (single-beat phases are always last).
  assign w_last_word = ((r_state == c_st_wr_key) & (r_word_cnt == 3'd5)) |
                       ((r_state == c_st_wr_pt)  & (r_word_cnt == 3'd3)) |
                       ((r_state == c_st_rd_ct)  & (r_word_cnt == 3'd3)) |
                       (r_state == c_st_wr_start);

`ifdef AES_DRV_POLL_TIMEOUT_EN
  localparam int c_poll_w = (POLL_LIMIT > 1) ? $clog2(POLL_LIMIT) : 1;
  localparam logic [c_poll_w-1:0] c_poll_last = c_poll_w'(POLL_LIMIT - 1);

  // Number of DONE reads so far in this job that came back not-done.
  logic [c_poll_w-1:0] r_poll_cnt;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_poll_cnt <= '0;
    end else if (w_accept) begin
      r_poll_cnt <= '0;
    end else if ((r_state == c_st_poll) && w_r_fire && !w_r_err && !m.m_r_data[0]) begin
      r_poll_cnt <= r_poll_cnt + c_poll_w'(1);
    end
  end

  assign w_poll_timeout = (r_state == c_st_poll) & w_r_fire & ~w_r_err &
                          ~m.m_r_data[0] & (r_poll_cnt == c_poll_last);
`else
  assign w_poll_timeout = 1'b0;
`endif

  // State register
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) r_state <= c_st_idle;
    else         r_state <= w_next;
  end

  // Next-state logic
  always_comb begin
    w_next = r_state;
    case (r_state)
      c_st_idle:     if (in_valid) w_next = c_st_wr_key;
      c_st_wr_key:   if (w_b_fire) w_next = w_b_err ? c_st_idle :
                                            (w_last_word ? c_st_wr_pt : c_st_wr_key);
      c_st_wr_pt:    if (w_b_fire) w_next = w_b_err ? c_st_idle :
                                            (w_last_word ? c_st_wr_start : c_st_wr_pt);
      c_st_wr_start: if (w_b_fire) w_next = w_b_err ? c_st_idle : c_st_poll;
      c_st_poll: begin
        if (w_r_fire) begin
          if (w_r_err || w_poll_timeout) w_next = c_st_idle;
          else if (m.m_r_data[0])        w_next = c_st_rd_ct;
          else                           w_next = c_st_poll;
        end
      end
      c_st_rd_ct:    if (w_r_fire) w_next = w_r_err ? c_st_idle :
                                            (w_last_word ? c_st_out : c_st_rd_ct);
      c_st_out:      if (out_ready) w_next = c_st_idle;
      default:       w_next = c_st_idle;
    endcase
  end

  // Outputs: derived only from registers so every output follows reset at once.
  always_comb begin
    in_ready     = (r_state == c_st_idle);
    busy_o       = (r_state != c_st_idle);
    err_o        = r_err;
    out_valid    = (r_state == c_st_out);
    out_ct       = (r_state == c_st_out) ? r_ct : 128'd0;
    m.m_aw_valid = w_wr_state & ~r_aw_done;
    m.m_w_valid  = w_wr_state & ~r_w_done;
    m.m_w_strb   = w_wr_state ? 4'hF : 4'h0;
    m.m_b_ready  = w_wr_state & r_aw_done & r_w_done;
    m.m_ar_valid = w_rd_state & ~r_ar_done;
    m.m_r_ready  = w_rd_state & r_ar_done;
    m.m_aw_addr  = 32'd0;
    m.m_w_data   = 32'd0;
    m.m_ar_addr  = 32'd0;
    case (r_state)
      c_st_wr_key: begin
        m.m_aw_addr = BASE_ADDR + c_off_key + {27'd0, r_word_cnt, 2'b00};
        m.m_w_data  = r_key[191:160];
      end
      c_st_wr_pt: begin
        m.m_aw_addr = BASE_ADDR + c_off_pt + {27'd0, r_word_cnt, 2'b00};
        m.m_w_data  = r_pt[127:96];
      end
      c_st_wr_start: begin
        m.m_aw_addr = BASE_ADDR + c_off_start;
        m.m_w_data  = 32'h1;
      end
      c_st_poll:  m.m_ar_addr = BASE_ADDR + c_off_done;
      c_st_rd_ct: m.m_ar_addr = BASE_ADDR + c_off_ct + {27'd0, r_word_cnt, 2'b00};
      default: ;
    endcase
  end

  // Datapath: job capture, per-channel handshake tracking, word shifting.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_aw_done  <= 1'b0;
      r_w_done   <= 1'b0;
      r_ar_done  <= 1'b0;
      r_word_cnt <= 3'd0;
      r_key      <= 192'd0;
      r_pt       <= 128'd0;
      r_ct       <= 128'd0;
      r_err      <= 1'b0;
    end else begin
      if (w_accept) begin
        r_key      <= in_key;
        r_pt       <= in_pt;
        r_word_cnt <= 3'd0;
      end

      if (m.m_aw_valid && m.m_aw_ready) r_aw_done <= 1'b1;
      if (m.m_w_valid && m.m_w_ready)   r_w_done  <= 1'b1;
      if (m.m_ar_valid && m.m_ar_ready) r_ar_done <= 1'b1;

      // Key and plaintext are shifted so the next word to send is always at the top.
      if (w_b_fire) begin
        r_aw_done <= 1'b0;
        r_w_done  <= 1'b0;
        if (r_state == c_st_wr_key) r_key <= {r_key[159:0], 32'd0};
        if (r_state == c_st_wr_pt)  r_pt  <= {r_pt[95:0], 32'd0};
        if ((r_state == c_st_wr_key) || (r_state == c_st_wr_pt))
          r_word_cnt <= w_last_word ? 3'd0 : r_word_cnt + 3'd1;
      end

      if (w_r_fire) begin
        r_ar_done <= 1'b0;
        if (r_state == c_st_rd_ct) begin
          r_ct       <= {r_ct[95:0], m.m_r_data};
          r_word_cnt <= w_last_word ? 3'd0 : r_word_cnt + 3'd1;
        end
      end

      if (w_b_err || w_r_err || w_poll_timeout) r_err <= 1'b1;
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_aes_axil_driver.sv
//------------------------------------------------------------------------------
// Module   : tb_aes_axil_driver
// Purpose  : Self-checking bench for aes_axil_driver with a behavioural
//            AXI4-Lite AES slave (configurable AW stall, DONE latency, CT
//            read error) and a table of directed jobs.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module tb_aes_axil_driver;

`ifdef AES_DRV_POLL_TIMEOUT_EN
  localparam int c_limit = 4;
`else
  localparam int c_limit = 1024;
`endif

  typedef struct {
    logic [191:0] key;
    logic [127:0] pt;
    logic [127:0] ct;
    int           aw_delay;
    int           done_zeros;
    int           out_delay;
  } vec_t;

  typedef struct {
    logic [31:0] addr;
    logic [31:0] data;
    int          aw_cyc;
    int          w_cyc;
  } wr_t;

  logic         clk = 1'b0;
  logic         rst_ni;
  logic         in_valid;
  logic         in_ready;
  logic [191:0] in_key;
  logic [127:0] in_pt;
  logic         out_valid;
  logic         out_ready;
  logic [127:0] out_ct;
  logic         busy_o;
  logic         err_o;

  aes_axil_driver_if axi();

  aes_axil_driver #(.BASE_ADDR(32'h0), .POLL_LIMIT(c_limit)) dut (
    .clk_i    (clk),
    .rst_ni   (rst_ni),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_key   (in_key),
    .in_pt    (in_pt),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_ct   (out_ct),
    .m        (axi),
    .busy_o   (busy_o),
    .err_o    (err_o)
  );

  always #5 clk = ~clk;

  // Slave configuration (written by the main sequence only)
  int           aw_delay;
  int           done_zeros;
  int           err_ct_word;
  logic [127:0] ct_cfg;

  // Slave-owned state and logs
  wr_t          wlog[$];
  int           done_seen;
  int           rd_count;
  int           proto_err;
  int           aw_wait, aw_cyc, w_cyc;
  bit           got_aw, got_w, got_ar;
  bit           aw_fire_n, w_fire_n, b_fire_n, ar_fire_n, r_fire_n;
  bit           prev_aw_pend, prev_w_pend, prev_ar_pend;
  logic [31:0]  prev_aw_addr, prev_w_data, prev_ar_addr;
  logic [31:0]  aw_addr_l, w_data_l, ar_addr_l;

  // Behavioural slave: decides on the falling edge; a handshake predicted here
  // happens on the next rising edge and is committed on the following fall.
  always @(negedge clk) begin
    logic [127:0] ct_tmp;
    int           idx;
    if (!rst_ni) begin
      axi.m_aw_ready = 1'b0; axi.m_w_ready = 1'b0; axi.m_ar_ready = 1'b0;
      axi.m_b_valid  = 1'b0; axi.m_b_resp  = 2'b00;
      axi.m_r_valid  = 1'b0; axi.m_r_resp  = 2'b00; axi.m_r_data = 32'd0;
      got_aw = 0; got_w = 0; got_ar = 0;
      aw_fire_n = 0; w_fire_n = 0; b_fire_n = 0; ar_fire_n = 0; r_fire_n = 0;
      prev_aw_pend = 0; prev_w_pend = 0; prev_ar_pend = 0;
      aw_wait = 0; aw_cyc = 0; w_cyc = 0;
    end else begin
      if (aw_fire_n) got_aw = 1;
      if (w_fire_n)  got_w  = 1;
      if (b_fire_n) begin
        axi.m_b_valid = 1'b0;
        wlog.push_back('{addr: aw_addr_l, data: w_data_l, aw_cyc: aw_cyc, w_cyc: w_cyc});
        if (aw_addr_l == 32'h28) done_seen = 0;
        got_aw = 0; got_w = 0; aw_cyc = 0; w_cyc = 0;
      end
      if (ar_fire_n) got_ar = 1;
      if (r_fire_n) begin
        axi.m_r_valid = 1'b0;
        got_ar = 0;
        rd_count++;
        if (ar_addr_l == 32'h2C) done_seen++;
      end

      if (prev_aw_pend && !(axi.m_aw_valid && axi.m_aw_addr == prev_aw_addr)) proto_err++;
      if (prev_w_pend  && !(axi.m_w_valid  && axi.m_w_data  == prev_w_data))  proto_err++;
      if (prev_ar_pend && !(axi.m_ar_valid && axi.m_ar_addr == prev_ar_addr)) proto_err++;
      if (axi.m_aw_valid && axi.m_w_valid && axi.m_w_strb != 4'hF) proto_err++;

      if (axi.m_aw_valid) aw_cyc++;
      if (axi.m_w_valid)  w_cyc++;

      if (axi.m_aw_valid && !got_aw) begin
        if (aw_wait < aw_delay) begin
          axi.m_aw_ready = 1'b0;
          aw_wait++;
        end else begin
          axi.m_aw_ready = 1'b1;
        end
      end else begin
        axi.m_aw_ready = 1'b0;
      end
      aw_fire_n = axi.m_aw_valid && axi.m_aw_ready;
      if (aw_fire_n) begin aw_addr_l = axi.m_aw_addr; aw_wait = 0; end

      axi.m_w_ready = axi.m_w_valid && !got_w;
      w_fire_n = axi.m_w_valid && axi.m_w_ready;
      if (w_fire_n) w_data_l = axi.m_w_data;

      if (got_aw && got_w && !axi.m_b_valid) begin
        axi.m_b_valid = 1'b1;
        axi.m_b_resp  = 2'b00;
      end
      b_fire_n = axi.m_b_valid && axi.m_b_ready;

      axi.m_ar_ready = axi.m_ar_valid && !got_ar;
      ar_fire_n = axi.m_ar_valid && axi.m_ar_ready;
      if (ar_fire_n) ar_addr_l = axi.m_ar_addr;

      if (got_ar && !axi.m_r_valid) begin
        axi.m_r_valid = 1'b1;
        if (ar_addr_l == 32'h2C) begin
          axi.m_r_data = (done_seen >= done_zeros) ? 32'h1 : 32'h0;
          axi.m_r_resp = 2'b00;
        end else begin
          idx    = int'((ar_addr_l - 32'h30) >> 2);
          ct_tmp = ct_cfg;
          axi.m_r_data = ct_tmp[127-32*idx -: 32];
          axi.m_r_resp = (idx == err_ct_word) ? 2'b10 : 2'b00;
        end
      end
      r_fire_n = axi.m_r_valid && axi.m_r_ready;

      prev_aw_pend = axi.m_aw_valid && !aw_fire_n; prev_aw_addr = axi.m_aw_addr;
      prev_w_pend  = axi.m_w_valid  && !w_fire_n;  prev_w_data  = axi.m_w_data;
      prev_ar_pend = axi.m_ar_valid && !ar_fire_n; prev_ar_addr = axi.m_ar_addr;
    end
  end

  int checks   = 0;
  int failures = 0;

  task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // Main sequence samples and drives 2 time units after each rising edge.
  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic accept_job(input logic [191:0] k, input logic [127:0] p, input string tag);
    int to;
    in_key = k; in_pt = p; in_valid = 1'b1;
    to = 0;
    do begin tick(); to++; end while (!busy_o && to < 50);
    in_valid = 1'b0;
    check({tag, "_accepted"}, busy_o, 1'b1);
  endtask

  task automatic run_vec(input vec_t v, input string tag);
    int           w0, to;
    logic [127:0] ct_seen;
    logic [191:0] k;
    logic [127:0] p;
    logic [31:0]  ea, ed;
    bit           stable, timing_ok;
    aw_delay = v.aw_delay; done_zeros = v.done_zeros; ct_cfg = v.ct; err_ct_word = -1;
    w0 = wlog.size();
    accept_job(v.key, v.pt, tag);
    to = 0;
    while (!out_valid && to < 3000) begin tick(); to++; end
    check({tag, "_out_valid"}, out_valid, 1'b1);
    check({tag, "_out_ct"}, out_ct, v.ct);
    ct_seen = out_ct;
    stable = 1;
    for (int c = 0; c < v.out_delay; c++) begin
      tick();
      if (out_valid !== 1'b1 || out_ct !== ct_seen || in_ready !== 1'b0) stable = 0;
    end
    check({tag, "_out_hold"}, stable, 1'b1);
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    check({tag, "_idle_after_out"}, {out_valid, in_ready, busy_o}, 3'b010);
    check({tag, "_write_count"}, wlog.size() - w0, 11);
    k = v.key; p = v.pt; timing_ok = 1;
    for (int i = 0; i < 11; i++) begin
      if (i < 6) begin
        ea = 32'h10 + 32'(4 * i); ed = k[191-32*i -: 32];
      end else if (i < 10) begin
        ea = 32'(4 * (i - 6)); ed = p[127-32*(i-6) -: 32];
      end else begin
        ea = 32'h28; ed = 32'h1;
      end
      if (wlog.size() > w0 + i) begin
        check($sformatf("%s_wr%0d", tag, i), {wlog[w0+i].addr, wlog[w0+i].data}, {ea, ed});
        if (wlog[w0+i].w_cyc != 1 || wlog[w0+i].aw_cyc != v.aw_delay + 1) timing_ok = 0;
      end
    end
    check({tag, "_aw_w_timing"}, timing_ok, 1'b1);
    check({tag, "_done_reads"}, done_seen, v.done_zeros + 1);
    check({tag, "_err"}, err_o, 1'b0);
  endtask

  vec_t vecs[3];

  initial begin
    int  to, r0;
    bit  found, saw_out;

    vecs[0] = '{key: 192'h000102030405060708090a0b0c0d0e0f1011121314151617,
                pt: 128'h00112233445566778899aabbccddeeff,
                ct: 128'hdda97ca4864cdfe06eaf70a0ec0d7191,
                aw_delay: 0, done_zeros: 0, out_delay: 0};
    vecs[1] = '{key: 192'h8e73b0f7da0e6452c810f32b809079e562f8ead2521f2c7b,
                pt: 128'h6bc1bee22e409f96e93d7e117393172a,
                ct: 128'hbd334f1d6e45f25ff712a214571fa5cc,
                aw_delay: 3, done_zeros: 5, out_delay: 10};
    vecs[2] = '{key: {192{1'b1}}, pt: 128'd0,
                ct: 128'h0123456789abcdeffedcba9876543210,
                aw_delay: 1, done_zeros: 2, out_delay: 1};

    rst_ni = 1'b0; in_valid = 1'b0; out_ready = 1'b0; in_key = '0; in_pt = '0;
    aw_delay = 0; done_zeros = 0; err_ct_word = -1; ct_cfg = '0;
    done_seen = 0; rd_count = 0; proto_err = 0;
    repeat (3) tick();
    check("reset_outputs",
          {in_ready, busy_o, err_o, out_valid, axi.m_aw_valid, axi.m_w_valid,
           axi.m_b_ready, axi.m_ar_valid, axi.m_r_ready},
          9'b100000000);
    check("reset_out_ct", out_ct, 128'd0);
    rst_ni = 1'b1;
    tick();

    foreach (vecs[i]) run_vec(vecs[i], $sformatf("vec%0d", i));
    if (wlog.size() > 0) check("first_write_key0", {wlog[0].addr, wlog[0].data}, {32'h10, 32'h00010203});
    else check("first_write_key0", 0, 1);

    // Reset pulse while the plaintext words are being written
    aw_delay = 0; done_zeros = 0; ct_cfg = vecs[0].ct;
    accept_job(vecs[0].key, vecs[0].pt, "rst_job");
    found = 0; to = 0;
    while (!found && to < 500) begin
      if (axi.m_aw_valid && axi.m_aw_addr < 32'h10) found = 1;
      else begin tick(); to++; end
    end
    check("rst_reached_wr_pt", found, 1'b1);
    #1 rst_ni = 1'b0;
    #1;
    check("rst_async_outputs",
          {axi.m_aw_valid, axi.m_w_valid, axi.m_b_ready, axi.m_ar_valid,
           axi.m_r_ready, out_valid, busy_o, in_ready},
          8'b00000001);
    repeat (2) tick();
    rst_ni = 1'b1;
    tick();
    run_vec(vecs[0], "post_rst");

`ifdef AES_DRV_POLL_TIMEOUT_EN
    // DONE never sets: exactly POLL_LIMIT reads, then error and back to idle
    done_zeros = 1000; aw_delay = 0;
    accept_job(vecs[0].key, vecs[0].pt, "timeout");
    to = 0; saw_out = 0;
    while (busy_o && to < 2000) begin tick(); to++; if (out_valid) saw_out = 1; end
    tick();
    check("timeout_err", err_o, 1'b1);
    check("timeout_done_reads", done_seen, 4);
    check("timeout_no_out", saw_out, 1'b0);
    rst_ni = 1'b0; tick(); rst_ni = 1'b1; tick();
    check("timeout_err_cleared_by_reset", err_o, 1'b0);
`endif

    // Error response on CT word 2
    aw_delay = 0; done_zeros = 1; ct_cfg = vecs[0].ct; err_ct_word = 2;
    accept_job(vecs[0].key, vecs[0].pt, "ct_err");
    r0 = rd_count; to = 0; saw_out = 0;
    while (!err_o && to < 3000) begin tick(); to++; if (out_valid) saw_out = 1; end
    check("ct_err_err_o", err_o, 1'b1);
    tick();
    check("ct_err_no_out", saw_out | out_valid, 1'b0);
    check("ct_err_idle", {in_ready, busy_o}, 2'b10);
    check("ct_err_reads", rd_count - r0, 5);
    repeat (5) tick();
    check("ct_err_sticky", err_o, 1'b1);
    err_ct_word = -1;

    check("axi_protocol", proto_err, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

endmodule

`default_nettype wire
